per_clk_rst_sequencer: RTL

- Multi-channel successor to the single-peripheral clock/reset control.
- Sequences each of NUM_CH peripherals through reset release, a parametrised clock-on delay, run, and glitch-free kernel-source switching.
- Runs in the bus clock domain and produces registered-state-decoded clock enables, reset, and selected source for downstream clock gates and muxes.
- Replaces the fixed per-peripheral "clock on N cycles after reset release" behaviour with per-channel FSMs, software reset re-entry, and source-switch gaps.

---
 rtl/per_clk_rst_sequencer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/per_clk_rst_sequencer.sv
// Per-channel clock/reset sequencer: reset release -> clock-on delay -> run, with gapped kernel-source switching.
// Latency: clk_en rises RST_DELAY+1 cycles after reset release; a source change costs SWITCH_GAP+1 clock-off cycles.
// No backpressure; sft_rst wins over every other event. Optional idle gating via PER_CLK_RST_SEQ_IDLE_GATE_EN.
module per_clk_rst_sequencer #(
    parameter int NUM_CH      = 4,
    parameter int SEL_W       = 2,
    parameter int RST_DELAY   = 2,
    parameter int SWITCH_GAP  = 3,
    parameter int SEL_RST     = 0,
    parameter int IDLE_CYCLES = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NUM_CH-1:0]       per_en,
    input  logic [NUM_CH-1:0]       sft_rst,
    input  logic [NUM_CH*SEL_W-1:0] sel_req,
    input  logic [NUM_CH-1:0]       ker_clk_req,
    output logic [NUM_CH-1:0]       clk_en,
    output logic [NUM_CH-1:0]       per_rst_n,
    output logic [NUM_CH*SEL_W-1:0] sel_out,
    output logic [NUM_CH-1:0]       busy
);

    typedef enum logic [1:0] {
        ST_RESET    = 2'd0,
        ST_WAIT_CLK = 2'd1,
        ST_RUN      = 2'd2,
        ST_SWITCH   = 2'd3
    } state_t;

    localparam logic [7:0]       RST_DELAY_C  = 8'(RST_DELAY);
    localparam logic [7:0]       SWITCH_GAP_C = 8'(SWITCH_GAP);
    localparam logic [SEL_W-1:0] SEL_RST_C    = SEL_W'(SEL_RST);

    state_t           state_q [NUM_CH];
    state_t           state_d [NUM_CH];
    logic [7:0]       cnt_q   [NUM_CH];
    logic [7:0]       cnt_d   [NUM_CH];
    logic [SEL_W-1:0] sel_q   [NUM_CH];
    logic [SEL_W-1:0] sel_d   [NUM_CH];
    logic [NUM_CH-1:0] idle_ok;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= ST_RESET;
                cnt_q[i]   <= '0;
                sel_q[i]   <= SEL_RST_C;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                sel_q[i]   <= sel_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            sel_d[i]   = sel_q[i];
            unique case (state_q[i])
                ST_RESET: begin
                    if (!sft_rst[i]) begin
                        state_d[i] = ST_WAIT_CLK;
                        cnt_d[i]   = RST_DELAY_C;
                    end
                end
                ST_WAIT_CLK: begin
                    if (sft_rst[i]) begin
                        state_d[i] = ST_RESET;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == 8'd0) begin
                        state_d[i] = ST_RUN;
                    end else begin
                        cnt_d[i] = cnt_q[i] - 8'd1;
                    end
                end
                ST_RUN: begin
                    if (sft_rst[i]) begin
                        state_d[i] = ST_RESET;
                        cnt_d[i]   = '0;
                    end else if (sel_req[i*SEL_W +: SEL_W] != sel_q[i]) begin
                        state_d[i] = ST_SWITCH;
                        cnt_d[i]   = SWITCH_GAP_C;
                    end
                end
                ST_SWITCH: begin
                    // An abort leaves the old source in place; the new one is only taken on a clean exit.
                    if (sft_rst[i]) begin
                        state_d[i] = ST_RESET;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == 8'd0) begin
                        state_d[i] = ST_RUN;
                        sel_d[i]   = sel_req[i*SEL_W +: SEL_W];
                    end else begin
                        cnt_d[i] = cnt_q[i] - 8'd1;
                    end
                end
                default: begin
                    state_d[i] = ST_RESET;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    always_comb begin
        clk_en    = '0;
        per_rst_n = '0;
        busy      = '0;
        sel_out   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            per_rst_n[i]               = (state_q[i] != ST_RESET);
            busy[i]                    = (state_q[i] != ST_RUN);
            clk_en[i]                  = (state_q[i] == ST_RUN) && per_en[i] && idle_ok[i];
            sel_out[i*SEL_W +: SEL_W]  = sel_q[i];
        end
    end

`ifdef PER_CLK_RST_SEQ_IDLE_GATE_EN
    localparam logic [7:0] IDLE_C = 8'(IDLE_CYCLES);
    logic [7:0] idle_q [NUM_CH];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_CH; i++) idle_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (state_q[i] != ST_RUN || ker_clk_req[i]) begin
                    idle_q[i] <= '0;
                end else if (idle_q[i] != IDLE_C) begin
                    idle_q[i] <= idle_q[i] + 8'd1;
                end
            end
        end
    end

    // A fresh request bypasses the saturated counter so the clock returns in the same cycle.
    always_comb begin
        idle_ok = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idle_ok[i] = ker_clk_req[i] || (idle_q[i] != IDLE_C);
        end
    end
`else
    logic unused_ker_clk_req;
    assign unused_ker_clk_req = ^ker_clk_req;
    assign idle_ok            = '1;
`endif

endmodule
